pc_ifid_control: RTL and testbench
==================================

# pc_ifid_control

Owns the program counter and the IF/ID pipeline register of the 5-stage MIPS pipeline. It drives `pc` into the fetch stage and captures the fetch stage's combinational outputs, `instruction` and `pc_plus4`, into IF/ID on each clock edge. It applies the hazard unit's stall and the branch and jump redirects, and on a redirect inserts a bubble into ID.

## Interface
Parameters:
- `inst_width`, 32: width of PC, instruction and PC+4.
- `reset_pc`, 32'h0000_0000: PC value loaded at reset.
- `nop_inst`, 32'h0000_0000: instruction word inserted as a bubble (`sll $0,$0,0`).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hazard unit; hold PC and IF/ID.
- `branch_taken`  in  1  EX-stage resolved taken branch.
- `branch_target`  in  inst_width  branch destination.
- `jump`  in  1  ID-stage jump (J/JAL/JR).
- `jump_target`  in  inst_width  jump destination.
- `fetch_instruction`  in  inst_width  instruction from the fetch stage.
- `fetch_pc_plus4`  in  inst_width  PC+4 from the fetch stage.
- `pc`  out  inst_width  current PC; feeds the fetch stage.
- `if_id_instruction`  out  inst_width  registered instruction to ID.
- `if_id_pc_plus4`  out  inst_width  registered PC+4 to ID.
- `if_id_valid`  out  1  1 when IF/ID holds a real instruction; 0 for a bubble.
- `misalign_err`  out  1  sticky; set when a redirect target has `[1:0]` not equal to 0.

## Operation
- All state updates on posedge `clk`. Per-edge action is chosen by fixed priority, highest first:
  1. `branch_taken`: `pc <= branch_target`; IF/ID <= bubble. Overrides `stall` and `jump`, because the branch is the older instruction.
  2. `stall`: hold `pc` and all IF/ID registers unchanged. A `jump` asserted while stalled is ignored this cycle. ID is holding the jump, so it re-asserts `jump` after the stall releases.
  3. `jump`: `pc <= jump_target`; IF/ID <= bubble. The sequentially fetched instruction is squashed.
  4. Otherwise (sequential): `pc <= fetch_pc_plus4`; `if_id_instruction <= fetch_instruction`; `if_id_pc_plus4 <= fetch_pc_plus4`; `if_id_valid <= 1`.
- Bubble means `if_id_instruction = nop_inst`, `if_id_pc_plus4 = 0`, `if_id_valid = 0`.
- Target alignment:
  - The loaded PC always has bits `[1:0]` forced to 2'b00.
  - If the selected target has nonzero `[1:0]`, `misalign_err` is set. This applies only to a target actually loaded (branch, or an unstalled jump).
  - `misalign_err` stays set until reset.
- PC arithmetic belongs to the fetch stage. This block adds nothing. PC wrap from 32'hFFFF_FFFC to 0 follows `fetch_pc_plus4` unchanged.
- The fetch stage is combinational from `pc`. The instruction at the new `pc` is therefore visible on `fetch_instruction` in the same cycle.

## Timing
- Reset (`rst_n` low, asynchronous, takes effect immediately without waiting for a clock edge):
  - `pc = reset_pc`
  - `if_id_instruction = nop_inst`
  - `if_id_pc_plus4 = 0`
  - `if_id_valid = 0`
  - `misalign_err = 0`
- Reset release: the first edge with `rst_n` high performs a normal priority decision.
- Reset asserted mid-stall or mid-redirect discards all pending state. No redirect is remembered.
- Latency:
  - `pc` to `if_id_*`: 1 cycle.
  - Redirect inputs to `pc`: 1 cycle.
  - A branch costs 2 bubbles: IF/ID is flushed at the branch edge, and the ID instruction is flushed externally by the hazard unit.
  - A jump costs 1 bubble.
- Stall: any number of consecutive cycles. Outputs are bit-identical throughout. No state is lost.
- `branch_taken` and `jump` in the same cycle: branch wins. The jump's target is never loaded.
- Outputs are registered only, with no combinational path from inputs to outputs.

## Test plan
- Reset/sequential:
  - Stimulus: `reset_pc = 0`; memory words are 0x11, 0x22, 0x33 at addresses 0, 4, 8; release `rst_n` and run 3 cycles.
  - Required: `pc` steps 0 → 4 → 8 → C. `if_id_instruction` steps 0x11 → 0x22 → 0x33. `if_id_valid` is 0 before the first edge and 1 after. `if_id_pc_plus4` steps 4 → 8 → C.
- Stall:
  - Stimulus: at `pc = 8`, assert `stall` for 3 cycles.
  - Required: `pc` stays 8 and IF/ID stays (0x22, 8, 1). On release, `pc` goes to C.
- Branch:
  - Stimulus: at `pc = C`, assert `branch_taken` with `branch_target = 0x40`, with `stall = 1` in the same cycle.
  - Required: `pc = 0x40`; IF/ID = (`nop_inst`, 0, 0). The next edge captures the instruction at 0x40 with valid = 1.
- Jump vs stall:
  - Stimulus: assert `jump` with `jump_target = 0x80` and `stall = 1` for 1 cycle, then `jump` alone.
  - Required: `pc` is held during the stalled cycle, then becomes 0x80 with a bubble in IF/ID.
- Simultaneous redirect:
  - Stimulus: `branch_taken` with target 0x100 and `jump` with target 0x200 in the same cycle.
  - Required: `pc = 0x100`.
- Misalign plus async reset:
  - Stimulus: `branch_target = 0x46`, then pulse `rst_n` low between clock edges.
  - Required: `pc = 0x44` and `misalign_err = 1`, holding over 5 sequential cycles. On `rst_n` falling, `misalign_err`, `pc` and `if_id_valid` return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_ifid_control_if.sv
// Bundle between the PC / IF-ID control block and its environment (hazard unit,
// redirect sources, fetch stage and decode stage).
interface pc_ifid_control_if #(
    parameter int inst_width = 32
);
    logic                  stall;
    logic                  branch_taken;
    logic [inst_width-1:0] branch_target;
    logic                  jump;
    logic [inst_width-1:0] jump_target;
    logic [inst_width-1:0] fetch_instruction;
    logic [inst_width-1:0] fetch_pc_plus4;
    logic [inst_width-1:0] pc;
    logic [inst_width-1:0] if_id_instruction;
    logic [inst_width-1:0] if_id_pc_plus4;
    logic                  if_id_valid;
    logic                  misalign_err;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               fetch_instruction, fetch_pc_plus4,
        input  pc, if_id_instruction, if_id_pc_plus4, if_id_valid, misalign_err
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               fetch_instruction, fetch_pc_plus4,
        output pc, if_id_instruction, if_id_pc_plus4, if_id_valid, misalign_err
    );
endinterface

// File: rtl/pc_ifid_control.sv
// Program counter and IF/ID pipeline register with stall, branch/jump redirect
// and bubble insertion for a 5-stage MIPS pipeline.
module pc_ifid_control #(
    parameter int                    inst_width = 32,
    parameter logic [inst_width-1:0] reset_pc   = 32'h0000_0000,
    parameter logic [inst_width-1:0] nop_inst   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_ifid_control_if.slave      bus
);

    typedef enum logic [1:0] {
        act_seq    = 2'b00,
        act_hold   = 2'b01,
        act_branch = 2'b10,
        act_jump   = 2'b11
    } action_t;

    function automatic logic is_misaligned(input logic [inst_width-1:0] target);
        return (target[1:0] != 2'b00);
    endfunction

    function automatic logic [inst_width-1:0] align_word(input logic [inst_width-1:0] target);
        return {target[inst_width-1:2], 2'b00};
    endfunction

    action_t               action_s;
    logic [inst_width-1:0] pc_r;
    logic [inst_width-1:0] if_id_instruction_r;
    logic [inst_width-1:0] if_id_pc_plus4_r;
    logic                  if_id_valid_r;
    logic                  misalign_err_r;
    logic [inst_width-1:0] pc_s;
    logic [inst_width-1:0] if_id_instruction_s;
    logic [inst_width-1:0] if_id_pc_plus4_s;
    logic                  if_id_valid_s;
    logic                  misalign_err_s;

    // Priority selection: the branch is the oldest instruction, so it beats stall and jump.
    always_comb begin
        action_s = act_seq;
        if (bus.branch_taken) begin
            action_s = act_branch;
        end else if (bus.stall) begin
            action_s = act_hold;
        end else if (bus.jump) begin
            action_s = act_jump;
        end else begin
            action_s = act_seq;
        end
    end

    // Next-state values for PC, IF/ID and the sticky misalignment flag.
    always_comb begin
        pc_s                = pc_r;
        if_id_instruction_s = if_id_instruction_r;
        if_id_pc_plus4_s    = if_id_pc_plus4_r;
        if_id_valid_s       = if_id_valid_r;
        misalign_err_s      = misalign_err_r;
        case (action_s)
            act_branch: begin
                pc_s                = align_word(bus.branch_target);
                if_id_instruction_s = nop_inst;
                if_id_pc_plus4_s    = {inst_width{1'b0}};
                if_id_valid_s       = 1'b0;
                misalign_err_s      = misalign_err_r | is_misaligned(bus.branch_target);
            end
            act_jump: begin
                pc_s                = align_word(bus.jump_target);
                if_id_instruction_s = nop_inst;
                if_id_pc_plus4_s    = {inst_width{1'b0}};
                if_id_valid_s       = 1'b0;
                misalign_err_s      = misalign_err_r | is_misaligned(bus.jump_target);
            end
            act_seq: begin
                // The fetch stage owns PC arithmetic, including wrap-around.
                pc_s                = bus.fetch_pc_plus4;
                if_id_instruction_s = bus.fetch_instruction;
                if_id_pc_plus4_s    = bus.fetch_pc_plus4;
                if_id_valid_s       = 1'b1;
            end
            act_hold: begin
                pc_s = pc_r;
            end
            default: begin
                pc_s = pc_r;
            end
        endcase
    end

    // State registers; reset discards any pending redirect or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r                <= reset_pc;
            if_id_instruction_r <= nop_inst;
            if_id_pc_plus4_r    <= {inst_width{1'b0}};
            if_id_valid_r       <= 1'b0;
            misalign_err_r      <= 1'b0;
        end else begin
            pc_r                <= pc_s;
            if_id_instruction_r <= if_id_instruction_s;
            if_id_pc_plus4_r    <= if_id_pc_plus4_s;
            if_id_valid_r       <= if_id_valid_s;
            misalign_err_r      <= misalign_err_s;
        end
    end

    assign bus.pc                = pc_r;
    assign bus.if_id_instruction = if_id_instruction_r;
    assign bus.if_id_pc_plus4    = if_id_pc_plus4_r;
    assign bus.if_id_valid       = if_id_valid_r;
    assign bus.misalign_err      = misalign_err_r;

endmodule

// File: tb/tb_pc_ifid_control.sv
// Directed bench for pc_ifid_control with a combinational fetch-stage model.
module tb_pc_ifid_control;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_ifid_control_if #(.inst_width(32)) bus ();

    pc_ifid_control #(
        .inst_width (32),
        .reset_pc   (32'h0000_0000),
        .nop_inst   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            default:       return 32'hC000_0000 | addr;
        endcase
    endfunction

    assign bus.fetch_instruction = mem_word(bus.pc);
    assign bus.fetch_pc_plus4    = bus.pc + 32'd4;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [31:0] e_pc,
                                input logic [31:0] e_ins, input logic [31:0] e_p4,
                                input logic e_v, input logic e_err);
        checks++;
        if ({bus.pc, bus.if_id_instruction, bus.if_id_pc_plus4, bus.if_id_valid, bus.misalign_err}
            !== {e_pc, e_ins, e_p4, e_v, e_err}) begin
            errors++;
            $display("FAIL %s: got pc=%h ins=%h p4=%h v=%b err=%b, expected pc=%h ins=%h p4=%h v=%b err=%b",
                     name, bus.pc, bus.if_id_instruction, bus.if_id_pc_plus4, bus.if_id_valid,
                     bus.misalign_err, e_pc, e_ins, e_p4, e_v, e_err);
        end
    endtask

    task automatic clear_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0000_0000;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0000_0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        expect_state("reset_state", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        #1;
        expect_state("before_first_edge", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_sequential();
        step();
        expect_state("seq_edge1", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0);
        step();
        expect_state("seq_edge2", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("stall_hold", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0);
        end
        bus.stall = 1'b0;
        step();
        expect_state("stall_release", 32'hC, 32'h33, 32'hC, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0040;
        bus.stall         = 1'b1;
        step();
        expect_state("branch_over_stall", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        clear_inputs();
        step();
        expect_state("branch_target_fetch", 32'h44, 32'hC000_0040, 32'h44, 1'b1, 1'b0);
    endtask

    task automatic test_jump_vs_stall();
        bus.jump        = 1'b1;
        bus.jump_target = 32'h0000_0080;
        bus.stall       = 1'b1;
        step();
        expect_state("jump_stalled", 32'h44, 32'hC000_0040, 32'h44, 1'b1, 1'b0);
        bus.stall = 1'b0;
        step();
        expect_state("jump_taken", 32'h80, 32'h0, 32'h0, 1'b0, 1'b0);
        clear_inputs();
        step();
        expect_state("jump_target_fetch", 32'h84, 32'hC000_0080, 32'h84, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0100;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h0000_0200;
        step();
        expect_state("branch_beats_jump", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        clear_inputs();
    endtask

    task automatic test_stalled_misaligned_jump_and_wrap();
        bus.jump        = 1'b1;
        bus.jump_target = 32'h0000_0083;
        bus.stall       = 1'b1;
        step();
        expect_state("stalled_bad_jump_ignored", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.stall       = 1'b0;
        bus.jump_target = 32'hFFFF_FFFC;
        step();
        expect_state("jump_to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        clear_inputs();
        step();
        expect_state("pc_wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_misalign_async_reset();
        logic [31:0] e_pc;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0046;
        step();
        expect_state("misalign_branch", 32'h44, 32'h0, 32'h0, 1'b0, 1'b1);
        clear_inputs();
        e_pc = 32'h44;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_state("misalign_sticky", e_pc + 32'd4, 32'hC000_0000 | e_pc, e_pc + 32'd4, 1'b1, 1'b1);
            e_pc = e_pc + 32'd4;
        end
        #1 rst_n = 1'b0;
        #1;
        expect_state("async_reset_midcycle", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        step();
        expect_state("after_reset_release", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_vs_stall();
        test_simultaneous();
        test_stalled_misaligned_jump_and_wrap();
        test_misalign_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
